tty: RTL and testbench

Console teletype interface on the PDP-6 IO bus. It is the device end of the IO bus: the processor drives selects and control pulses, and this block answers them. It decodes CONO/DATAO/CONI/DATAI for its device code and runs an 8N1 serial transmitter and receiver. It raises a priority-interrupt request on its assigned channel.

---
 rtl/tty_pkg.sv | 33 +++
 rtl/tty_if.sv | 28 ++
 rtl/tty_rx.sv | 104 ++++++++++
 rtl/tty.sv | 174 +++++++++++++++++
 tb/tb_tty.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tty_pkg.sv
// Shared PDP-6 IO bus definitions: device codes, CONO/CONI bit positions,
// serial FSM state encodings and the one-hot priority-interrupt decode.
package tty_pkg;

  localparam logic [0:6] DEV_APR = 7'o000;
  localparam logic [0:6] DEV_PI  = 7'o001;
  localparam logic [0:6] DEV_PTP = 7'o020;
  localparam logic [0:6] DEV_PTR = 7'o021;
  localparam logic [0:6] DEV_TTY = 7'o024;

  localparam int CONO_TTI_CLR  = 25;
  localparam int CONO_TTO_CLR  = 26;
  localparam int CONO_TTI_SET  = 27;
  localparam int CONO_TTO_SET  = 28;
  localparam int CONI_TTI_BUSY = 29;
  localparam int CONI_TTI_FLAG = 30;
  localparam int CONI_TTO_BUSY = 31;
  localparam int CONI_TTO_FLAG = 32;
  localparam int PIA_LSB       = 33;  // pia occupies [33:35]
  localparam int DATA_MSB      = 28;  // character occupies [28:35]

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [1:7] pi_decode(input logic [0:2] chan);
    logic [1:7] req;
    req = '0;
    for (int i = 1; i <= 7; i++)
      if (int'(chan) == i) req[i] = 1'b1;
    return req;
  endfunction

endpackage

// File: rtl/tty_if.sv
// PDP-6 IO bus as seen by one device: processor-driven selects/pulses and
// the device-driven ORed data and PI request lines.
interface tty_if;
  logic        iob_poweron;
  logic        iob_reset;
  logic        datao_clear;
  logic        datao_set;
  logic        cono_clear;
  logic        cono_set;
  logic        iob_fm_datai;
  logic        iob_fm_status;
  logic [3:9]  ios;
  logic [0:35] iob_out;
  logic [1:7]  pi_req;
  logic [0:35] iob_in;

  modport master (
    output iob_poweron, iob_reset, datao_clear, datao_set, cono_clear, cono_set,
           iob_fm_datai, iob_fm_status, ios, iob_out,
    input  pi_req, iob_in
  );

  modport slave (
    input  iob_poweron, iob_reset, datao_clear, datao_set, cono_clear, cono_set,
           iob_fm_datai, iob_fm_status, ios, iob_out,
    output pi_req, iob_in
  );
endinterface

// File: rtl/tty_rx.sv
// Teletype 8N1 receiver: rxd synchronizer, bit-timing FSM and input buffer tib.
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on synchronized rxd
//   RX_START | half-bit wait, then re-check that the line is still low
//   RX_DATA  | sample 8 data bits at bit centres, LSB first
//   RX_STOP  | sample stop bit; high delivers the character, low drops it
module tty_rx import tty_pkg::*; #(
  parameter int BIT_CYCLES = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       rxd,
  output logic [0:7] tib,
  output logic       rx_done,
  output logic       rx_busy
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_BIT  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2 - 1);

  logic          rxd_s1, rxd_s2, rxd_prev;
  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [0:7]    shift, shift_nxt;

  // Synchronizer flops clear to the idle-high level so a clear never fakes a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tib      <= '0;
    end else if (clr) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tib      <= '0;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      if (rx_done) tib <= shift;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    rx_done     = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (rxd_prev && !rxd_s2) begin
          state_nxt = RX_START;
          cnt_nxt   = CNT_HALF;
        end
      end
      RX_START: begin
        if (cnt != '0) cnt_nxt = cnt - CW'(1);
        else if (rxd_s2) state_nxt = RX_IDLE;
        else begin
          state_nxt   = RX_DATA;
          cnt_nxt     = CNT_BIT;
          bit_idx_nxt = '0;
        end
      end
      RX_DATA: begin
        if (cnt != '0) cnt_nxt = cnt - CW'(1);
        else begin
          shift_nxt = {rxd_s2, shift[0:6]};
          cnt_nxt   = CNT_BIT;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt != '0) cnt_nxt = cnt - CW'(1);
        else begin
          state_nxt = RX_IDLE;
          rx_done   = rxd_s2;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  assign rx_busy = (state != RX_IDLE);

endmodule

// File: rtl/tty.sv
// PDP-6 console teletype: IO bus decode (CONO/CONI/DATAO/DATAI), flags, PI
// channel and the 8N1 transmitter; the receiver lives in tty_rx.
//   state    | meaning
//   TX_IDLE  | line idle high, waiting for an accepted DATAO
//   TX_START | start bit (txd low)
//   TX_DATA  | 8 data bits from the shift register, LSB first
//   TX_STOP  | stop bit (txd high); its end completes the character
module tty import tty_pkg::*; #(
  parameter logic [0:6] DEVCODE    = DEV_TTY,
  parameter int         BIT_CYCLES = 434
) (
  input  logic  clk,
  input  logic  reset,
  tty_if.slave  iobus,
  input  logic  tti_rxd,
  output logic  tto_txd
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CNT_BIT = CW'(BIT_CYCLES - 1);

  logic          sel, dev_clr, cono_set_sel, datao_go, datai_fall;
  logic [0:2]    pia;
  logic          tti_flag, tto_flag, tti_busy, tto_busy;
  logic [0:7]    tob, tob_or, tib;
  logic          fm_datai_q, rx_done, tx_done, txd_nxt;
  logic [1:7]    pi_req_q;
  logic [0:35]   iob_in_c;
  tx_state_t     tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]    tx_bit, tx_bit_nxt;
  logic [0:7]    tx_shift, tx_shift_nxt;
  logic          unused_iob_out;

  assign sel            = (iobus.ios == DEVCODE);
  assign dev_clr        = iobus.iob_reset | ~iobus.iob_poweron;
  assign cono_set_sel   = sel & iobus.cono_set;
  assign datao_go       = sel & iobus.datao_set & ~tto_busy;
  assign datai_fall     = sel & fm_datai_q & ~iobus.iob_fm_datai;
  assign tob_or         = tob | iobus.iob_out[DATA_MSB:35];
  assign tto_busy       = (tx_state != TX_IDLE);
  assign unused_iob_out = ^iobus.iob_out[0:24];

  tty_rx #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .clr     (dev_clr),
    .rxd     (tti_rxd),
    .tib     (tib),
    .rx_done (rx_done),
    .rx_busy (tti_busy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pia        <= '0;
      tti_flag   <= 1'b0;
      tto_flag   <= 1'b0;
      tob        <= '0;
      fm_datai_q <= 1'b0;
      pi_req_q   <= '0;
    end else if (dev_clr) begin
      pia        <= '0;
      tti_flag   <= 1'b0;
      tto_flag   <= 1'b0;
      tob        <= '0;
      fm_datai_q <= 1'b0;
      pi_req_q   <= '0;
    end else begin
      fm_datai_q <= iobus.iob_fm_datai;
      if (cono_set_sel) pia <= iobus.iob_out[PIA_LSB:35];
      else if (sel && iobus.cono_clear) pia <= '0;
      if (sel && iobus.datao_clear) tob <= '0;
      else if (datao_go) tob <= tob_or;
      // Completions and CONO sets take priority over any clear in the same cycle.
      if (rx_done || (cono_set_sel && iobus.iob_out[CONO_TTI_SET])) tti_flag <= 1'b1;
      else if ((cono_set_sel && iobus.iob_out[CONO_TTI_CLR]) || datai_fall) tti_flag <= 1'b0;
      if (tx_done || (cono_set_sel && iobus.iob_out[CONO_TTO_SET])) tto_flag <= 1'b1;
      else if ((cono_set_sel && iobus.iob_out[CONO_TTO_CLR]) || datao_go) tto_flag <= 1'b0;
      pi_req_q <= (tti_flag || tto_flag) ? pi_decode(pia) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tto_txd  <= 1'b1;
    end else if (dev_clr) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tto_txd  <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      tto_txd  <= txd_nxt;
    end
  end

  // txd is registered from the next-state decode so the line never glitches.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    txd_nxt      = tto_txd;
    tx_done      = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (datao_go) begin
          tx_state_nxt = TX_START;
          tx_cnt_nxt   = CNT_BIT;
          tx_shift_nxt = tob_or;
          txd_nxt      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt != '0) tx_cnt_nxt = tx_cnt - CW'(1);
        else begin
          tx_state_nxt = TX_DATA;
          tx_cnt_nxt   = CNT_BIT;
          tx_bit_nxt   = '0;
          txd_nxt      = tx_shift[7];
          tx_shift_nxt = {1'b0, tx_shift[0:6]};
        end
      end
      TX_DATA: begin
        if (tx_cnt != '0) tx_cnt_nxt = tx_cnt - CW'(1);
        else begin
          tx_cnt_nxt = CNT_BIT;
          if (tx_bit == 3'd7) begin
            tx_state_nxt = TX_STOP;
            txd_nxt      = 1'b1;
          end else begin
            tx_bit_nxt   = tx_bit + 3'd1;
            txd_nxt      = tx_shift[7];
            tx_shift_nxt = {1'b0, tx_shift[0:6]};
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt != '0) tx_cnt_nxt = tx_cnt - CW'(1);
        else begin
          tx_state_nxt = TX_IDLE;
          tx_done      = 1'b1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    iob_in_c = '0;
    if (sel && !dev_clr) begin
      if (iobus.iob_fm_status) begin
        iob_in_c[PIA_LSB:35]   = pia;
        iob_in_c[CONI_TTO_FLAG] = tto_flag;
        iob_in_c[CONI_TTO_BUSY] = tto_busy;
        iob_in_c[CONI_TTI_FLAG] = tti_flag;
        iob_in_c[CONI_TTI_BUSY] = tti_busy;
      end
      if (iobus.iob_fm_datai) iob_in_c[DATA_MSB:35] = iob_in_c[DATA_MSB:35] | tib;
    end
  end

  assign iobus.iob_in = iob_in_c;
  assign iobus.pi_req = pi_req_q;

endmodule

// File: tb/tb_tty.sv
// Directed bench for tty: stimulus queues expected values, a negedge monitor
// pops and compares whenever a probe cycle is presented.
module tb_tty;
  localparam int B = 16;
  localparam logic [6:0] DEV = 7'o024;
  localparam int K_IOB = 0;
  localparam int K_TXD = 1;
  localparam int K_PI  = 2;

  typedef struct {
    int          kind;
    string       name;
    logic [35:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        txd;
  logic        probe = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [35:0] mon_act;
  int          exp_wave [10];

  tty_if iobus();

  tty #(.DEVCODE(DEV), .BIT_CYCLES(B)) u_dut (
    .clk     (clk),
    .reset   (rst_n),
    .iobus   (iobus),
    .tti_rxd (rxd),
    .tto_txd (txd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (probe) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: probe presented with no expected value queued");
      end else begin
        mon_e = sb.pop_front();
        case (mon_e.kind)
          K_TXD:   mon_act = {35'b0, txd};
          K_PI:    mon_act = {29'b0, iobus.pi_req};
          default: mon_act = iobus.iob_in;
        endcase
        if (mon_act !== mon_e.val) begin
          n_fail++;
          $display("FAIL %s: got %o, expected %o", mon_e.name, mon_act, mon_e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input string name, input logic [35:0] val);
    exp_t e;
    e.kind = kind;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic coni(input string name, input logic [35:0] val);
    iobus.iob_fm_status = 1'b1;
    chk(K_IOB, name, val);
    iobus.iob_fm_status = 1'b0;
  endtask

  task automatic datai(input string name, input logic [35:0] val);
    iobus.iob_fm_datai = 1'b1;
    chk(K_IOB, name, val);
    iobus.iob_fm_datai = 1'b0;
  endtask

  task automatic cono(input logic [35:0] w);
    iobus.iob_out = w;
    iobus.cono_clear = 1'b1;
    tick();
    iobus.cono_clear = 1'b0;
    tick();
    iobus.cono_set = 1'b1;
    tick();
    iobus.cono_set = 1'b0;
    iobus.iob_out = '0;
  endtask

  task automatic datao(input logic [35:0] w);
    iobus.iob_out = w;
    iobus.datao_clear = 1'b1;
    tick();
    iobus.datao_clear = 1'b0;
    tick();
    iobus.datao_set = 1'b1;
    tick();
    iobus.datao_set = 1'b0;
    iobus.iob_out = '0;
  endtask

  task automatic send_char(input logic [7:0] ch, input logic stop_bit);
    rxd = 1'b0;
    repeat (B) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = ch[i];
      repeat (B) tick();
    end
    rxd = stop_bit;
    repeat (B) tick();
    rxd = 1'b1;
  endtask

  // Expected CONI word: pia in [33:35], tto_flag 32, tto_busy 31, tti_flag 30, tti_busy 29.
  function automatic logic [35:0] cw(input int pia, input bit tof, input bit tob_b,
                                     input bit tif, input bit tib_b);
    logic [35:0] r;
    r    = 36'(pia);
    r[3] = tof;
    r[4] = tob_b;
    r[5] = tif;
    r[6] = tib_b;
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_wave = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
    iobus.iob_poweron   = 1'b1;
    iobus.iob_reset     = 1'b0;
    iobus.datao_clear   = 1'b0;
    iobus.datao_set     = 1'b0;
    iobus.cono_clear    = 1'b0;
    iobus.cono_set      = 1'b0;
    iobus.iob_fm_datai  = 1'b0;
    iobus.iob_fm_status = 1'b0;
    iobus.ios           = DEV;
    iobus.iob_out       = '0;
    repeat (2) tick();
    chk(K_TXD, "txd_in_reset", 36'd1);
    chk(K_PI,  "pi_in_reset", 36'd0);
    chk(K_IOB, "iob_in_in_reset", 36'd0);
    rst_n = 1'b1;
    tick();
    coni("coni_after_reset", 36'd0);

    cono(36'o5);
    tick();
    coni("coni_pia5", cw(5, 0, 0, 0, 0));
    chk(K_PI, "pi_no_flag", 36'd0);

    // Character 0o101: start, LSB-first data, stop, sampled mid-bit.
    datao(36'o101);
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? B / 2 : B - 2) tick();
      chk(K_TXD, $sformatf("txd_bit%0d", k), 36'(exp_wave[k]));
      coni($sformatf("busy_bit%0d", k), cw(5, 0, 1, 0, 0));
    end
    repeat (B) tick();
    coni("coni_tx_done", cw(5, 1, 0, 0, 0));
    chk(K_PI, "pi_tx_done", 36'b0000100);

    cono(36'o1205);
    tick();
    coni("coni_set_wins", cw(5, 1, 0, 0, 0));
    cono(36'o1005);
    tick();
    coni("coni_tto_clr", cw(5, 0, 0, 0, 0));
    chk(K_PI, "pi_after_clr", 36'd0);

    send_char(8'o132, 1'b1);
    repeat (2) tick();
    coni("coni_rx_done", cw(5, 0, 0, 1, 0));
    chk(K_PI, "pi_rx", 36'b0000100);
    datai("datai_rx", 36'o132);
    repeat (2) tick();
    coni("coni_after_datai", cw(5, 0, 0, 0, 0));
    chk(K_PI, "pi_after_datai", 36'd0);

    rxd = 1'b0;
    repeat (3) tick();
    coni("coni_glitch_busy", cw(5, 0, 0, 0, 1));
    tick();
    rxd = 1'b1;
    repeat (2 * B) tick();
    coni("coni_glitch_done", cw(5, 0, 0, 0, 0));
    datai("datai_glitch", 36'o132);

    send_char(8'o045, 1'b0);
    repeat (2) tick();
    coni("coni_framing", cw(5, 0, 0, 0, 0));
    datai("datai_framing", 36'o132);

    cono(36'o405);
    tick();
    send_char(8'o063, 1'b1);
    repeat (2) tick();
    coni("coni_overrun", cw(5, 0, 0, 1, 0));
    datai("datai_overrun", 36'o063);
    repeat (2) tick();

    iobus.ios = 7'o025;
    coni("coni_wrong_ios", 36'd0);
    datao(36'o177);
    cono(36'o0);
    repeat (2) tick();
    chk(K_TXD, "txd_wrong_ios", 36'd1);
    iobus.ios = DEV;
    coni("coni_after_wrong_ios", cw(5, 0, 0, 0, 0));

    datao(36'o101);
    repeat (4 * B + B / 2) tick();
    chk(K_TXD, "txd_bit3", 36'd0);
    iobus.iob_reset = 1'b1;
    tick();
    iobus.iob_reset = 1'b0;
    chk(K_TXD, "txd_after_iob_reset", 36'd1);
    coni("coni_after_iob_reset", 36'd0);
    chk(K_PI, "pi_after_iob_reset", 36'd0);
    datai("datai_after_iob_reset", 36'd0);

    repeat (2) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected values left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
